data_memory_unit: RTL and testbench
===================================

# data_memory_unit

Parametrised, pipelined successor to the CPU's flat data/instruction memory. It provides a handshaked data port supporting the BYTE, HALFWORD, WORD, WORDLEFT and WORDRIGHT load/store modes from MemoryModesPackage, with byte-lane writes, sign or zero extension, and one-cycle registered reads. An independent registered instruction-fetch port is also provided. After reset, a hardware sweep zero-initialises the array. The block sits between the CPU's MEM stage and IF stage and the block-RAM.

## Interface
- DEPTH_WORDS, 16384: number of 32-bit words; power of two, 16..65536; byte space is DEPTH_WORDS*4.
- INIT_CLEAR, 1: 1 = zero-sweep after reset; 0 = array contents undefined and ready immediately.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  data-port request present.
- req_ready  out  1  data port can accept this cycle.
- address  in  32  byte address; bits above log2(DEPTH_WORDS*4) are ignored (wrap).
- data  in  32  store data.
- writeMode  in  3  memory mode enum; NONE = no store.
- readMode  in  3  memory mode enum; NONE = no load.
- unsignedLoad  in  1  1 = zero-extend BYTE/HALFWORD loads.
- rsp_valid  out  1  dataOutput/rsp_error valid this cycle.
- dataOutput  out  32  load result.
- rsp_error  out  1  request was rejected (see Operation).
- pcAddress  in  32  fetch byte address; bits [1:0] ignored.
- pcDataOutput  out  32  fetched word.
- init_done  out  1  sweep complete.

## Operation
- FSM states: INIT, RUN. After reset: INIT if INIT_CLEAR=1, else RUN.
- INIT: writes 0 to word index 0, 1, ... DEPTH_WORDS-1, one word per cycle. When the last word is written, move to RUN. req_ready=0 and init_done=0 while in INIT.
- RUN: req_ready=1 and init_done=1. A request is accepted when req_valid && req_ready. Back-to-back acceptance every cycle.
- Byte order is little-endian: byte offset k = address[1:0] selects bits [8k+7:8k] of the word.
- Stores:
  - BYTE: byte k = data[7:0].
  - HALFWORD: bytes k,k+1 = data[15:0].
  - WORD: all bytes.
  - WORDLEFT at k: memory bytes k..0 = data bytes 3..3-k (offset 0 writes data[31:24] to byte 0).
  - WORDRIGHT at k: memory bytes k..3 = data bytes 0..3-k.
- Loads:
  - BYTE/HALFWORD: sign-extended unless unsignedLoad=1.
  - WORD: unchanged.
  - WORDLEFT at k: result bytes 3..3-k = memory bytes k..0, remaining bytes 0.
  - WORDRIGHT at k: result bytes 3-k..0 = memory bytes 3..k, upper bytes 0.
- Accepted with both modes NONE: no effect, no response.
- Accepted with both modes non-NONE: no store, error response.
- Error response: rsp_valid=1, rsp_error=1, dataOutput=0. Store responses are produced only on error.
- Fetch port: active in RUN only. pcDataOutput = word at pcAddress[log2(DEPTH_WORDS*4)-1:2].

## Timing
- Load latency is 1 cycle. rsp_valid and dataOutput are asserted the cycle after acceptance, for exactly one cycle.
- Store commits at the accepting edge. A load accepted the next cycle returns the new data.
- Fetch latency is 1 cycle, read-first: a fetch of a word being stored in the same cycle returns the old contents.
- Reset values: req_ready=0, rsp_valid=0, rsp_error=0, dataOutput=0, pcDataOutput=0, init_done=0. With INIT_CLEAR=0, req_ready and init_done go to 1 on the first cycle after reset deasserts.
- Reset asserted mid-INIT restarts the sweep from word 0. Reset asserted with a load in flight drops its response.
- Sweep length: DEPTH_WORDS cycles. init_done rises on the cycle after the last word write.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - HALFWORD with address[0]=1, or WORD with address[1:0]≠0, gives an error response and the store is suppressed.
  - WORDLEFT/WORDRIGHT are never misaligned.
- MEM_MISALIGN_TRAP_EN undefined:
  - Low address bits are forced to alignment (HALFWORD clears bit 0; WORD clears bits 1:0).
  - The access proceeds with no error.

## Test plan
- Reset, INIT_CLEAR=1, DEPTH_WORDS=16: init_done rises exactly 16 cycles after reset release. A WORD load at every address returns 0.
- WORD store 0x22345678 @65532, then WORD load @65532 -> 0x22345678 one cycle after acceptance. HALFWORD load of 0xFFFF -> 0xFFFFFFFF signed, 0x0000FFFF with unsignedLoad=1.
- BYTE stores B2@+2, D4@+0, A1@+3, C3@+1 -> WORD load 0xA1B2C3D4. Signed BYTE load @+3 -> 0xFFFFFFA1.
- Starting from a zeroed word, WORDLEFT 0x12345678 @ offsets 0,1,2,3 -> WORD 0x12, 0x1234, 0x123456, 0x12345678. WORDRIGHT 0x0000ABCD @ offset 3 over 0x12345678 -> 0xCD345678.
- Same-cycle store to word N and fetch of word N -> pcDataOutput returns old value, next fetch returns new. Reset pulsed mid-sweep -> sweep restarts, init_done delayed by full DEPTH_WORDS.
- WORD store @65530: with MEM_MISALIGN_TRAP_EN -> rsp_error=1 and the word is unchanged. Without it -> the store lands at 65528. Both modes non-NONE -> rsp_error=1 and no store.

Source files
------------

// File: rtl/data_memory_unit.sv
// Pipelined data memory: handshaked byte/half/word/left/right load-store port, registered
// read-first fetch port and post-reset zero sweep. Optional: MEM_MISALIGN_TRAP_EN.
package MemoryModesPackage;
  typedef enum logic [2:0] {
    NONE      = 3'd0,
    BYTE      = 3'd1,
    HALFWORD  = 3'd2,
    WORD      = 3'd3,
    WORDLEFT  = 3'd4,
    WORDRIGHT = 3'd5
  } MemoryMode;
endpackage

module data_memory_unit
  import MemoryModesPackage::*;
#(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter bit          INIT_CLEAR  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] address,
  input  logic [31:0] data,
  input  logic [2:0]  writeMode,
  input  logic [2:0]  readMode,
  input  logic        unsignedLoad,
  output logic        rsp_valid,
  output logic [31:0] dataOutput,
  output logic        rsp_error,
  input  logic [31:0] pcAddress,
  output logic [31:0] pcDataOutput,
  output logic        init_done
);

  localparam int unsigned WI = $clog2(DEPTH_WORDS);
  localparam int unsigned AW = WI + 2;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [WI-1:0]   r_sweep_idx;
  logic [31:0]     r_mem [DEPTH_WORDS];

  MemoryMode       w_wmode, w_rmode, w_mode;
  logic            w_wr_act, w_rd_act, w_accept, w_err, w_misalign, w_store, w_load;
  logic [1:0]      w_off;
  logic [3:0]      w_st_be;
  logic [31:0]     w_st_data;
  logic            w_mem_we;
  logic [WI-1:0]   w_mem_idx;
  logic [3:0]      w_mem_be;
  logic [31:0]     w_mem_wdata;

  logic [31:0]     r_rd_word;
  MemoryMode       r_ld_mode;
  logic [1:0]      r_ld_off;
  logic            r_ld_uns;
  logic            r_rsp_valid, r_rsp_error;
  logic [31:0]     r_pc_data;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_fmt;
  logic            w_unused;

  assign w_wmode  = MemoryMode'(writeMode);
  assign w_rmode  = MemoryMode'(readMode);
  assign w_wr_act = (w_wmode != NONE);
  assign w_rd_act = (w_rmode != NONE);
  assign w_mode   = w_wr_act ? w_wmode : w_rmode;
  assign w_accept = req_valid && (r_state == S_RUN);

  always_comb begin
    w_off      = address[1:0];
    w_misalign = 1'b0;
    case (w_mode)
`ifdef MEM_MISALIGN_TRAP_EN
      HALFWORD: w_misalign = address[0];
      WORD:     w_misalign = (address[1:0] != 2'b00);
`else
      HALFWORD: w_off[0] = 1'b0;
      WORD:     w_off    = 2'b00;
`endif
      default: ;
    endcase
  end

  assign w_err   = (w_wr_act && w_rd_act) || w_misalign;
  assign w_store = w_accept && w_wr_act && !w_err;
  assign w_load  = w_accept && w_rd_act && !w_err;

  // Store data is pre-shifted so that byte lane j always takes w_st_data[8j+7:8j].
  always_comb begin
    w_st_be   = '0;
    w_st_data = data;
    case (w_wmode)
      BYTE: begin
        w_st_be   = 4'b0001 << w_off;
        w_st_data = {4{data[7:0]}};
      end
      HALFWORD: begin
        w_st_be   = 4'b0011 << w_off;
        w_st_data = {2{data[15:0]}};
      end
      WORD: w_st_be = '1;
      WORDLEFT: begin
        w_st_be   = 4'b1111 >> (2'd3 - w_off);
        w_st_data = data >> {(2'd3 - w_off), 3'b000};
      end
      WORDRIGHT: begin
        w_st_be   = 4'b1111 << w_off;
        w_st_data = data << {w_off, 3'b000};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_mem_we    = w_store;
    w_mem_idx   = address[AW-1:2];
    w_mem_be    = w_st_be;
    w_mem_wdata = w_st_data;
    if (r_state == S_INIT) begin
      w_mem_we    = INIT_CLEAR;
      w_mem_idx   = r_sweep_idx;
      w_mem_be    = '1;
      w_mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_mem_be[b]) r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
      end
    end
    if (w_load) r_rd_word <= r_mem[address[AW-1:2]];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_INIT;
      r_sweep_idx <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_ld_mode   <= NONE;
      r_ld_off    <= '0;
      r_ld_uns    <= 1'b0;
      r_pc_data   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) r_sweep_idx <= r_sweep_idx + WI'(1);
      r_rsp_valid <= w_load || (w_accept && w_err);
      r_rsp_error <= w_accept && w_err;
      if (w_load) begin
        r_ld_mode <= w_rmode;
        r_ld_off  <= w_off;
        r_ld_uns  <= unsignedLoad;
      end
      if (r_state == S_RUN) r_pc_data <= r_mem[pcAddress[AW-1:2]];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT: if (!INIT_CLEAR || (r_sweep_idx == WI'(DEPTH_WORDS - 1))) w_state_nxt = S_RUN;
      S_RUN:  w_state_nxt = S_RUN;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Load formatting works on the registered raw word, keeping the array read path plain.
  always_comb begin
    w_byte = r_rd_word[{r_ld_off, 3'b000} +: 8];
    w_half = r_ld_off[1] ? r_rd_word[31:16] : r_rd_word[15:0];
    w_fmt  = '0;
    case (r_ld_mode)
      BYTE:      w_fmt = {{24{w_byte[7] & ~r_ld_uns}}, w_byte};
      HALFWORD:  w_fmt = {{16{w_half[15] & ~r_ld_uns}}, w_half};
      WORD:      w_fmt = r_rd_word;
      WORDLEFT:  w_fmt = r_rd_word << {(2'd3 - r_ld_off), 3'b000};
      WORDRIGHT: w_fmt = r_rd_word >> {r_ld_off, 3'b000};
      default:   w_fmt = '0;
    endcase
  end

  assign req_ready    = (r_state == S_RUN);
  assign init_done    = (r_state == S_RUN);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_error    = r_rsp_error;
  assign dataOutput   = (r_rsp_valid && !r_rsp_error) ? w_fmt : '0;
  assign pcDataOutput = r_pc_data;

  assign w_unused = ^{address[31:AW], pcAddress[31:AW], pcAddress[1:0]};

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: directed scenarios and randomized back-to-back traffic
// compared against a byte-array reference model of the memory.
module tb_data_memory_unit;
  import MemoryModesPackage::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] address;
  logic [31:0] data;
  logic [2:0]  writeMode;
  logic [2:0]  readMode;
  logic        unsignedLoad;
  logic        rsp_valid;
  logic [31:0] dataOutput;
  logic        rsp_error;
  logic [31:0] pcAddress;
  logic [31:0] pcDataOutput;
  logic        init_done;

  logic        nc_req_ready, nc_rsp_valid, nc_rsp_error, nc_init_done;
  logic [31:0] nc_dataOutput, nc_pc_unused;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  mm [BYTES];

  always #5 clk = ~clk;

  data_memory_unit #(.DEPTH_WORDS(DEPTH), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .address(address), .data(data), .writeMode(writeMode), .readMode(readMode),
    .unsignedLoad(unsignedLoad), .rsp_valid(rsp_valid), .dataOutput(dataOutput),
    .rsp_error(rsp_error), .pcAddress(pcAddress), .pcDataOutput(pcDataOutput),
    .init_done(init_done)
  );

  data_memory_unit #(.DEPTH_WORDS(DEPTH), .INIT_CLEAR(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .req_valid(1'b0), .req_ready(nc_req_ready),
    .address(32'd0), .data(32'd0), .writeMode(3'd0), .readMode(3'd0),
    .unsignedLoad(1'b0), .rsp_valid(nc_rsp_valid), .dataOutput(nc_dataOutput),
    .rsp_error(nc_rsp_error), .pcAddress(32'd0), .pcDataOutput(nc_pc_unused),
    .init_done(nc_init_done)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int i = 0; i < int'(BYTES); i++) mm[i] = 8'h00;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int unsigned base;
    logic [31:0] r;
    base = ((a % BYTES) / 4) * 4;
    r = '0;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = mm[base + j];
    return r;
  endfunction

  function automatic bit model_err(input logic [2:0] wm, input logic [2:0] rm, input logic [31:0] a);
    logic [2:0] m;
    if (wm != NONE && rm != NONE) return 1'b1;
    m = (wm != NONE) ? wm : rm;
`ifdef MEM_MISALIGN_TRAP_EN
    if (m == HALFWORD && (a % 2) != 0) return 1'b1;
    if (m == WORD && (a % 4) != 0) return 1'b1;
`else
    if (m == NONE || a == 32'hFFFF_FFFF) return 1'b0;
`endif
    return 1'b0;
  endfunction

  function automatic void model_store(input logic [2:0] wm, input logic [31:0] a, input logic [31:0] d);
    int unsigned ab, base, k;
    ab = a % BYTES; base = (ab / 4) * 4; k = ab % 4;
    case (wm)
      BYTE:     mm[base + k] = d[7:0];
      HALFWORD: begin
        k = (k / 2) * 2;
        mm[base + k] = d[7:0];
        mm[base + k + 1] = d[15:8];
      end
      WORD:      for (int unsigned j = 0; j < 4; j++) mm[base + j] = d[8*j +: 8];
      WORDLEFT:  for (int unsigned j = 0; j <= k; j++) mm[base + j] = d[8*(3 - k + j) +: 8];
      WORDRIGHT: for (int unsigned j = k; j < 4; j++) mm[base + j] = d[8*(j - k) +: 8];
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] rm, input logic [31:0] a, input logic uns);
    int unsigned ab, base, k;
    logic [31:0] r;
    ab = a % BYTES; base = (ab / 4) * 4; k = ab % 4;
    r = '0;
    case (rm)
      BYTE: begin
        r = 32'(mm[base + k]);
        if (!uns && r >= 32'd128) r = r - 32'd256;
      end
      HALFWORD: begin
        k = (k / 2) * 2;
        r = 32'(mm[base + k]) + 32'(mm[base + k + 1]) * 32'd256;
        if (!uns && r >= 32'd32768) r = r - 32'd65536;
      end
      WORD:      r = model_word(a);
      WORDLEFT:  for (int unsigned j = 0; j <= k; j++) r[8*(3 - k + j) +: 8] = mm[base + j];
      WORDRIGHT: for (int unsigned j = k; j < 4; j++) r[8*(j - k) +: 8] = mm[base + j];
      default: ;
    endcase
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] wm, input logic [2:0] rm, input logic [31:0] a,
                     input logic [31:0] d, input logic uns);
    writeMode = wm; readMode = rm; address = a; data = d; unsignedLoad = uns;
    req_valid = 1'b1;
    if (wm != NONE && !model_err(wm, rm, a)) model_store(wm, a, d);
    tick();
    req_valid = 1'b0; writeMode = NONE; readMode = NONE;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; writeMode = NONE; readMode = NONE;
    address = '0; data = '0; unsignedLoad = 1'b0; pcAddress = '0;
    repeat (3) tick();
    checks++; if ({req_ready, rsp_valid, rsp_error, init_done} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {req_ready, rsp_valid, rsp_error, init_done}); end
    checks++; if (dataOutput !== 32'h0) begin
      errors++; $display("FAIL reset_dataOutput: got %h expected 00000000", dataOutput); end
    checks++; if (pcDataOutput !== 32'h0) begin
      errors++; $display("FAIL reset_pcData: got %h expected 00000000", pcDataOutput); end
    checks++; if ({nc_req_ready, nc_init_done} !== 2'b00) begin
      errors++; $display("FAIL nc_reset_ready: got %b expected 00", {nc_req_ready, nc_init_done}); end
    rst = 1'b1;
    tick();
    checks++; if ({nc_req_ready, nc_init_done, nc_rsp_valid, nc_rsp_error} !== 4'b1100) begin
      errors++; $display("FAIL nc_ready_first_cycle: got %b expected 1100",
                         {nc_req_ready, nc_init_done, nc_rsp_valid, nc_rsp_error}); end
    checks++; if (nc_dataOutput !== 32'h0) begin
      errors++; $display("FAIL nc_dataOutput: got %h expected 00000000", nc_dataOutput); end
    repeat (14) tick();
    checks++; if ({init_done, req_ready} !== 2'b00) begin
      errors++; $display("FAIL sweep_not_done_15: got %b expected 00", {init_done, req_ready}); end
    checks++; if (pcDataOutput !== 32'h0) begin
      errors++; $display("FAIL fetch_idle_in_init: got %h expected 00000000", pcDataOutput); end
    tick();
    checks++; if ({init_done, req_ready} !== 2'b11) begin
      errors++; $display("FAIL sweep_done_16: got %b expected 11", {init_done, req_ready}); end
    model_clear();
    for (int i = 0; i < int'(DEPTH); i++) begin
      req(NONE, WORD, 32'(4 * i), 32'h0, 1'b0);
      checks++; if (rsp_valid !== 1'b1 || dataOutput !== 32'h0) begin
        errors++; $display("FAIL swept_word_%0d: got v=%b %h expected v=1 00000000", i, rsp_valid, dataOutput); end
    end
  endtask

  task automatic test_word_half();
    req(WORD, NONE, 32'd65532, 32'h22345678, 1'b0);
    checks++; if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL store_no_response: got %b expected 0", rsp_valid); end
    req(NONE, WORD, 32'd65532, 32'h0, 1'b0);
    checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || dataOutput !== 32'h22345678) begin
      errors++; $display("FAIL word_load: got v=%b e=%b %h expected v=1 e=0 22345678", rsp_valid, rsp_error, dataOutput); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rsp_one_cycle: got %b expected 0", rsp_valid); end
    req(HALFWORD, NONE, 32'd65532, 32'h0000FFFF, 1'b0);
    req(NONE, HALFWORD, 32'd65532, 32'h0, 1'b0);
    checks++; if (dataOutput !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL half_signed: got %h expected ffffffff", dataOutput); end
    req(NONE, HALFWORD, 32'd65532, 32'h0, 1'b1);
    checks++; if (dataOutput !== 32'h0000FFFF) begin
      errors++; $display("FAIL half_unsigned: got %h expected 0000ffff", dataOutput); end
  endtask

  task automatic test_bytes();
    logic [1:0] offs [4];
    logic [7:0] vals [4];
    offs = '{2'd2, 2'd0, 2'd3, 2'd1};
    vals = '{8'hB2, 8'hD4, 8'hA1, 8'hC3};
    for (int i = 0; i < 4; i++) req(BYTE, NONE, 32'h100 + 32'(offs[i]), {24'h0, vals[i]}, 1'b0);
    req(NONE, WORD, 32'h100, 32'h0, 1'b0);
    checks++; if (dataOutput !== 32'hA1B2C3D4) begin
      errors++; $display("FAIL byte_lanes: got %h expected a1b2c3d4", dataOutput); end
    req(NONE, BYTE, 32'h103, 32'h0, 1'b0);
    checks++; if (dataOutput !== 32'hFFFFFFA1) begin
      errors++; $display("FAIL byte_signed: got %h expected ffffffa1", dataOutput); end
    req(NONE, BYTE, 32'h103, 32'h0, 1'b1);
    checks++; if (dataOutput !== 32'h000000A1) begin
      errors++; $display("FAIL byte_unsigned: got %h expected 000000a1", dataOutput); end
  endtask

  task automatic test_word_left_right();
    logic [31:0] exp_l [4];
    exp_l = '{32'h00000012, 32'h00001234, 32'h00123456, 32'h12345678};
    for (int k = 0; k < 4; k++) begin
      req(WORD, NONE, 32'd4, 32'h0, 1'b0);
      req(WORDLEFT, NONE, 32'(4 + k), 32'h12345678, 1'b0);
      req(NONE, WORD, 32'd4, 32'h0, 1'b0);
      checks++; if (dataOutput !== exp_l[k]) begin
        errors++; $display("FAIL wordleft_store_%0d: got %h expected %h", k, dataOutput, exp_l[k]); end
    end
    req(WORD, NONE, 32'd4, 32'h12345678, 1'b0);
    req(WORDRIGHT, NONE, 32'd7, 32'h0000ABCD, 1'b0);
    req(NONE, WORD, 32'd4, 32'h0, 1'b0);
    checks++; if (dataOutput !== 32'hCD345678) begin
      errors++; $display("FAIL wordright_store: got %h expected cd345678", dataOutput); end
    req(NONE, WORDLEFT, 32'd5, 32'h0, 1'b0);
    checks++; if (dataOutput !== 32'h56780000) begin
      errors++; $display("FAIL wordleft_load: got %h expected 56780000", dataOutput); end
    req(NONE, WORDRIGHT, 32'd5, 32'h0, 1'b0);
    checks++; if (dataOutput !== 32'h00CD3456) begin
      errors++; $display("FAIL wordright_load: got %h expected 00cd3456", dataOutput); end
  endtask

  task automatic test_fetch_read_first();
    pcAddress = 32'h0001_000B;
    req(WORD, NONE, 32'd8, 32'hAAAA5555, 1'b0);
    tick();
    checks++; if (pcDataOutput !== 32'hAAAA5555) begin
      errors++; $display("FAIL fetch_basic: got %h expected aaaa5555", pcDataOutput); end
    req(WORD, NONE, 32'd8, 32'h0BADF00D, 1'b0);
    checks++; if (pcDataOutput !== 32'hAAAA5555) begin
      errors++; $display("FAIL fetch_read_first: got %h expected aaaa5555", pcDataOutput); end
    tick();
    checks++; if (pcDataOutput !== 32'h0BADF00D) begin
      errors++; $display("FAIL fetch_new: got %h expected 0badf00d", pcDataOutput); end
  endtask

  task automatic test_misalign_and_conflict();
    logic        exp_rv;
    logic [31:0] exp_w;
`ifdef MEM_MISALIGN_TRAP_EN
    exp_rv = 1'b1; exp_w = 32'h11111111;
`else
    exp_rv = 1'b0; exp_w = 32'h55667788;
`endif
    req(WORD, NONE, 32'd56, 32'h11111111, 1'b0);
    req(WORD, NONE, 32'd65530, 32'h55667788, 1'b0);
    checks++; if (rsp_valid !== exp_rv || rsp_error !== exp_rv) begin
      errors++; $display("FAIL misalign_rsp: got v=%b e=%b expected v=%b e=%b", rsp_valid, rsp_error, exp_rv, exp_rv); end
    req(NONE, WORD, 32'd65528, 32'h0, 1'b0);
    checks++; if (dataOutput !== exp_w) begin
      errors++; $display("FAIL misalign_word: got %h expected %h", dataOutput, exp_w); end
    req(WORD, WORD, 32'd56, 32'h99999999, 1'b0);
    checks++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || dataOutput !== 32'h0) begin
      errors++; $display("FAIL both_modes_rsp: got v=%b e=%b %h expected v=1 e=1 00000000", rsp_valid, rsp_error, dataOutput); end
    req(NONE, WORD, 32'd56, 32'h0, 1'b0);
    checks++; if (dataOutput !== exp_w) begin
      errors++; $display("FAIL both_modes_no_store: got %h expected %h", dataOutput, exp_w); end
  endtask

  task automatic test_random_back_to_back();
    logic [2:0]  wm, rm;
    logic [31:0] a, d, pc, exp_pc, exp_d;
    logic        uns, v, exp_v, exp_e;
    int unsigned kind;
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      wm = NONE; rm = NONE;
      if (kind <= 3) wm = 3'($urandom_range(1, 5));
      else if (kind <= 6) rm = 3'($urandom_range(1, 5));
      else if (kind >= 8) begin wm = 3'($urandom_range(1, 5)); rm = 3'($urandom_range(1, 5)); end
      v = (kind != 9);
      a = $urandom(); d = $urandom(); pc = $urandom(); uns = 1'($urandom_range(0, 1));
      exp_pc = model_word(pc);
      exp_v = 1'b0; exp_e = 1'b0; exp_d = 32'h0;
      if (v && (wm != NONE || rm != NONE)) begin
        if (model_err(wm, rm, a)) begin exp_v = 1'b1; exp_e = 1'b1; end
        else if (rm != NONE) begin exp_v = 1'b1; exp_d = model_load(rm, a, uns); end
        else model_store(wm, a, d);
      end
      writeMode = wm; readMode = rm; address = a; data = d; unsignedLoad = uns;
      pcAddress = pc; req_valid = v;
      tick();
      checks++; if (rsp_valid !== exp_v || rsp_error !== exp_e) begin
        errors++; $display("FAIL rand_rsp_%0d: got v=%b e=%b expected v=%b e=%b (w=%0d r=%0d a=%h)",
                           i, rsp_valid, rsp_error, exp_v, exp_e, wm, rm, a); end
      if (exp_v) begin
        checks++; if (dataOutput !== exp_d) begin
          errors++; $display("FAIL rand_data_%0d: got %h expected %h (r=%0d a=%h u=%b)", i, dataOutput, exp_d, rm, a, uns); end
      end
      checks++; if (pcDataOutput !== exp_pc) begin
        errors++; $display("FAIL rand_fetch_%0d: got %h expected %h (pc=%h)", i, pcDataOutput, exp_pc, pc); end
    end
    req_valid = 1'b0; writeMode = NONE; readMode = NONE;
  endtask

  task automatic test_reset_recovery();
    writeMode = NONE; readMode = WORD; address = 32'd60; req_valid = 1'b1; rst = 1'b0;
    tick();
    req_valid = 1'b0; readMode = NONE;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL load_dropped_by_reset: got v=%b rdy=%b expected v=0 rdy=0", rsp_valid, req_ready); end
    rst = 1'b1;
    repeat (5) tick();
    checks++; if (init_done !== 1'b0) begin
      errors++; $display("FAIL mid_sweep_busy: got %b expected 0", init_done); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (15) tick();
    checks++; if (init_done !== 1'b0) begin
      errors++; $display("FAIL restart_not_done_15: got %b expected 0", init_done); end
    tick();
    checks++; if (init_done !== 1'b1) begin
      errors++; $display("FAIL restart_done_16: got %b expected 1", init_done); end
    model_clear();
    req(NONE, WORD, 32'd56, 32'h0, 1'b0);
    checks++; if (dataOutput !== 32'h0) begin
      errors++; $display("FAIL cleared_after_restart: got %h expected 00000000", dataOutput); end
  endtask

  initial begin
    test_reset();
    test_word_half();
    test_bytes();
    test_word_left_right();
    test_fetch_read_first();
    test_misalign_and_conflict();
    test_random_back_to_back();
    test_reset_recovery();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
